// File: rtl/uart_word_tx_engine_pkg.sv
// Shared definitions for the word-to-serial UART TX engine: FSM states,
// ASCII offsets, legal chunk sizes and the nibble-to-hex-ASCII helper.
// No ports. Imported by uart_word_fifo and uart_word_tx_engine.
package uart_word_tx_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_DIGIT_OFS = 8'h30;   // '0'
   localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;   // 'A' - 10
   localparam int         CHUNK_NIBBLE    = 4;
   localparam int         CHUNK_BYTE      = 8;

   // 0..9 -> '0'..'9', 10..15 -> 'A'..'F'
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (ASCII_DIGIT_OFS + {4'h0, n})
                         : (ASCII_ALPHA_OFS + {4'h0, n});
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Purpose: synchronous word FIFO with drop-on-full; head word visible on rd_data.
// Latency: a word written in cycle N is visible at the head (empty=0) in cycle N+1.
// Backpressure: none upstream; a write while full without a same-cycle pop is dropped and flagged on drop.
// Ports: clk/reset (async active-low), wr_en/wr_data push side, rd_en pop side,
//        rd_data head word, full/empty status, drop = this cycle's write was discarded.
module uart_word_fifo
   import uart_word_tx_engine_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic             drop
);

   localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_rd;
   logic             do_wr;

   // A pop frees a slot in the same cycle, so a write into a full FIFO is
   // still accepted when it coincides with a pop.
   assign do_rd = rd_en && (count != '0);
   assign do_wr = wr_en && ((count != FULL_CNT) || do_rd);

   assign rd_data = mem[rd_ptr];
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign drop    = wr_en && !do_wr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap naturally.
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: count/pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("uart_word_fifo: DEPTH must be a power of two and >= 2");
   end

endmodule

// File: rtl/uart_word_tx_engine.sv
// Purpose: buffers CPU words and streams them as CHUNK_BITS chunks (optionally hex-ASCII) to a byte UART.
// Latency: wr_en in cycle N into an idle, empty engine -> pop in N+1 -> tx_start in N+2.
// Backpressure: one byte in flight; next tx_start only after tx_done. Full FIFO drops writes and sets overflow.
// Ports: clk, reset (async active-low); wr_en/wr_data word push; clr_flags_n clears sticky flags;
//        tx_done/tx_start/tx_byte byte-transmitter handshake; busy, fifo_full, fifo_empty,
//        overflow (sticky drop), done_flag (bit0 sticky: a full word has been sent).
module uart_word_tx_engine
   import uart_word_tx_engine_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CHUNK_BITS = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int MSB_FIRST  = 0,
   parameter int HEX_ASCII  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  clr_flags_n,
   input  logic                  tx_done,
   output logic                  tx_start,
   output logic [7:0]            tx_byte,
   output logic                  busy,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  overflow,
   output logic [DATA_WIDTH-1:0] done_flag
);

   localparam int             NCHUNK     = DATA_WIDTH / CHUNK_BITS;
   localparam int             CW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0]  LAST_CHUNK = CW'(NCHUNK - 1);

   state_t                state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] shift_next;
   logic [CW-1:0]         chunk_cnt;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  fifo_pop;
   logic                  fifo_drop;
   logic                  word_done;
   logic                  done_bit;

   // Extract the chunk that is next on the wire and encode it as a byte.
   function automatic logic [7:0] enc_chunk(input logic [DATA_WIDTH-1:0] sr);
      logic [CHUNK_BITS-1:0] c;
      c = (MSB_FIRST != 0) ? sr[DATA_WIDTH-1 -: CHUNK_BITS] : sr[CHUNK_BITS-1:0];
      if (CHUNK_BITS == CHUNK_NIBBLE && HEX_ASCII != 0)
         return hex_ascii(4'(c));
      return 8'(c);
   endfunction

   uart_word_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .drop    (fifo_drop)
   );

   // The FSM only pops from IDLE, so a pop never races an empty FIFO.
   assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
   assign shift_next = (MSB_FIRST != 0) ? (shift_reg << CHUNK_BITS)
                                        : (shift_reg >> CHUNK_BITS);
   assign word_done  = (state == ST_WAIT) && tx_done && (chunk_cnt == LAST_CHUNK);
   assign busy       = (state != ST_IDLE);
   assign done_flag  = {{(DATA_WIDTH-1){1'b0}}, done_bit};

   // tx_byte is loaded on the transition into SEND so it is already valid
   // when tx_start is high, and it is held untouched until the next load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         chunk_cnt <= '0;
         tx_start  <= 1'b0;
         tx_byte   <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  shift_reg <= fifo_head;
                  chunk_cnt <= '0;
                  tx_byte   <= enc_chunk(fifo_head);
                  tx_start  <= 1'b1;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               // tx_done here belongs to no byte of ours and is ignored.
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (tx_done) begin
                  if (chunk_cnt == LAST_CHUNK) begin
                     state <= ST_IDLE;
                  end else begin
                     shift_reg <= shift_next;
                     chunk_cnt <= chunk_cnt + 1'b1;
                     tx_byte   <= enc_chunk(shift_next);
                     tx_start  <= 1'b1;
                     state     <= ST_SEND;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sticky flags: a set event in the same cycle as a clear wins, so a
   // completion or drop is never lost to a concurrent software clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_bit <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (word_done)         done_bit <= 1'b1;
         else if (!clr_flags_n) done_bit <= 1'b0;
         if (fifo_drop)         overflow <= 1'b1;
         else if (!clr_flags_n) overflow <= 1'b0;
      end
   end

   if ((DATA_WIDTH % CHUNK_BITS) != 0 ||
       (CHUNK_BITS != CHUNK_NIBBLE && CHUNK_BITS != CHUNK_BYTE)) begin : g_bad_chunk
      $error("uart_word_tx_engine: CHUNK_BITS must be 4 or 8 and divide DATA_WIDTH");
   end

endmodule

// File: tb/tb_uart_word_tx_engine.sv
// Bench for uart_word_tx_engine: three instances cover the default nibble/hex
// mode, MSB-first raw bytes and nibble without ASCII encoding. A byte-transmitter
// responder answers every tx_start after a random delay and logs the bytes.
module tb_uart_word_tx_engine;

   logic        clk;
   logic        reset;
   logic [2:0]  wr_en;
   logic [31:0] wr_data [3];
   logic        clr_flags_n;
   logic [2:0]  tx_done;
   logic [2:0]  rsp_done;
   logic        tx_done_force;
   logic [2:0]  tx_start;
   logic [7:0]  tx_byte [3];
   logic [2:0]  busy;
   logic [2:0]  fifo_full;
   logic [2:0]  fifo_empty;
   logic [2:0]  overflow;
   logic [31:0] done_flag [3];

   int          n_assert = 0;
   int          n_fail   = 0;
   int          proto_err = 0;
   int          cd [3];
   logic [7:0]  held [3];
   int          start_cnt [3];
   logic [9:0]  got_q [$];
   logic [9:0]  exp_q [$];
   int          gi = 0;
   int          ei = 0;

   assign tx_done = rsp_done | {2'b00, tx_done_force};

   uart_word_tx_engine #(.DATA_WIDTH(32), .CHUNK_BITS(4), .FIFO_DEPTH(4), .MSB_FIRST(0), .HEX_ASCII(1)) d0 (
      .clk(clk), .reset(reset), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .clr_flags_n(clr_flags_n),
      .tx_done(tx_done[0]), .tx_start(tx_start[0]), .tx_byte(tx_byte[0]), .busy(busy[0]),
      .fifo_full(fifo_full[0]), .fifo_empty(fifo_empty[0]), .overflow(overflow[0]), .done_flag(done_flag[0]));

   uart_word_tx_engine #(.DATA_WIDTH(32), .CHUNK_BITS(8), .FIFO_DEPTH(4), .MSB_FIRST(1), .HEX_ASCII(1)) d1 (
      .clk(clk), .reset(reset), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .clr_flags_n(clr_flags_n),
      .tx_done(tx_done[1]), .tx_start(tx_start[1]), .tx_byte(tx_byte[1]), .busy(busy[1]),
      .fifo_full(fifo_full[1]), .fifo_empty(fifo_empty[1]), .overflow(overflow[1]), .done_flag(done_flag[1]));

   uart_word_tx_engine #(.DATA_WIDTH(32), .CHUNK_BITS(4), .FIFO_DEPTH(4), .MSB_FIRST(0), .HEX_ASCII(0)) d2 (
      .clk(clk), .reset(reset), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .clr_flags_n(clr_flags_n),
      .tx_done(tx_done[2]), .tx_start(tx_start[2]), .tx_byte(tx_byte[2]), .busy(busy[2]),
      .fifo_full(fifo_full[2]), .fifo_empty(fifo_empty[2]), .overflow(overflow[2]), .done_flag(done_flag[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-transmitter stand-in: log each tx_start byte, demand it stays stable
   // while in flight, answer with a one-cycle tx_done 1..4 cycles later.
   initial begin
      rsp_done = '0;
      for (int k = 0; k < 3; k++) begin cd[k] = 0; held[k] = '0; start_cnt[k] = 0; end
   end
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         if (!reset) begin
            cd[k] = 0;
            rsp_done[k] = 1'b0;
         end else begin
            rsp_done[k] = 1'b0;
            if (cd[k] > 0) begin
               if (tx_byte[k] !== held[k]) proto_err++;
               cd[k]--;
               if (cd[k] == 0) rsp_done[k] = 1'b1;
            end
            if (tx_start[k] === 1'b1) begin
               if (cd[k] > 0) proto_err++;
               got_q.push_back({2'(k), tx_byte[k]});
               held[k] = tx_byte[k];
               start_cnt[k]++;
               cd[k] = $urandom_range(1, 4);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: chunk i of a word is taken by position arithmetic, then mapped
   // to a character ('0'-'9','A'-'F'), a raw byte or a zero-extended nibble.
   task automatic model_word(input int k, input logic [31:0] w, input int limit);
      int cb, n, sh;
      logic [7:0] c, b;
      cb = (k == 1) ? 8 : 4;
      n  = 32 / cb;
      for (int i = 0; i < n && i < limit; i++) begin
         sh = (k == 1) ? (n - 1 - i) * cb : i * cb;
         c  = 8'((w >> sh) & ((32'd1 << cb) - 1));
         if (k == 1)      b = c;
         else if (k == 0) b = (c < 10) ? 8'(int'("0") + c) : 8'(int'("A") + c - 10);
         else             b = c;
         exp_q.push_back({2'(k), b});
      end
   endtask

   task automatic write_word(input int k, input logic [31:0] w, input bit expect_sent);
      wr_en[k] = 1'b1;
      wr_data[k] = w;
      tick();
      wr_en[k] = 1'b0;
      wr_data[k] = $urandom;
      if (expect_sent) model_word(k, w, 99);
   endtask

   task automatic drain(input int k);
      int idle;
      bit ok;
      idle = 0;
      ok = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (!busy[k] && fifo_empty[k] && cd[k] == 0) idle++; else idle = 0;
         if (idle >= 3) begin ok = 1; break; end
      end
      check("drain_timeout", {31'b0, ok}, 32'd1);
   endtask

   task automatic compare_bytes(input string tag);
      int ng, ne;
      ng = got_q.size() - gi;
      ne = exp_q.size() - ei;
      check({tag, "_count"}, ng, ne);
      for (int j = 0; j < ne && j < ng; j++) check(tag, got_q[gi + j], exp_q[ei + j]);
      gi = got_q.size();
      ei = exp_q.size();
   endtask

   task automatic pulse_clr();
      clr_flags_n = 1'b0;
      tick();
      clr_flags_n = 1'b1;
   endtask

   initial begin
      logic [31:0] w [7];
      int n, base;
      bit ok;
      reset = 1'b0;
      wr_en = '0;
      for (int k = 0; k < 3; k++) wr_data[k] = '0;
      clr_flags_n = 1'b1;
      tx_done_force = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_tx_start", tx_start, 3'b000);
      check("rst_tx_byte", tx_byte[0], 8'h00);
      check("rst_busy", busy, 3'b000);
      check("rst_fifo_empty", fifo_empty, 3'b111);
      check("rst_fifo_full", fifo_full, 3'b000);
      check("rst_overflow", overflow, 3'b000);
      check("rst_done_flag", done_flag[0], 32'd0);
      reset = 1'b1;
      repeat (2) tick();

      // 1: nibble/hex LSB-first, plus pop/tx_start latency
      write_word(0, 32'h1234ABCD, 1);
      check("lat_fifo_not_empty", fifo_empty[0], 1'b0);
      check("lat_idle_at_write", busy[0], 1'b0);
      tick();
      check("lat_tx_start", tx_start[0], 1'b1);
      check("lat_first_byte", tx_byte[0], 8'h44);
      check("lat_popped", fifo_empty[0], 1'b1);
      drain(0);
      compare_bytes("t1_bytes");
      check("t1_done_flag", done_flag[0], 32'd1);
      for (int i = 0; i < 3; i++) begin
         write_word(0, $urandom, 1);
         repeat ($urandom_range(0, 20)) tick();
      end
      drain(0);
      compare_bytes("t1_rand_bytes");

      // 2: MSB-first raw bytes
      write_word(1, 32'hDEADBEEF, 1);
      drain(1);
      compare_bytes("t2_bytes");
      check("t2_done_flag", done_flag[1], 32'd1);
      write_word(1, $urandom, 1);
      write_word(1, $urandom, 1);
      drain(1);
      compare_bytes("t2_rand_bytes");

      // 3: overflow, clear, write+pop while full
      for (int i = 0; i < 7; i++) w[i] = $urandom;
      write_word(0, w[0], 1);
      tick();
      check("t3_first_start", tx_start[0], 1'b1);
      for (int i = 1; i <= 4; i++) write_word(0, w[i], 1);
      check("t3_full", fifo_full[0], 1'b1);
      check("t3_no_overflow_yet", overflow[0], 1'b0);
      write_word(0, w[5], 0);
      check("t3_overflow", overflow[0], 1'b1);
      pulse_clr();
      check("t3_ovf_cleared", overflow[0], 1'b0);
      check("t3_done_cleared", done_flag[0], 32'd0);
      check("t3_still_full", fifo_full[0], 1'b1);
      ok = 0;
      for (int c = 0; c < 2000; c++) begin
         if (!busy[0]) begin ok = 1; break; end
         tick();
      end
      check("t3_idle_timeout", {31'b0, ok}, 32'd1);
      check("t3_full_at_pop", fifo_full[0], 1'b1);
      write_word(0, w[6], 1);
      check("t3_full_after_wr_pop", fifo_full[0], 1'b1);
      check("t3_no_drop_wr_pop", overflow[0], 1'b0);
      drain(0);
      compare_bytes("t3_bytes");

      // 4: stray tx_done in IDLE/SEND, clear coinciding with final tx_done
      pulse_clr();
      check("t4_done_cleared", done_flag[0], 32'd0);
      tx_done_force = 1'b1;
      repeat (2) tick();
      tx_done_force = 1'b0;
      tick();
      check("t4_idle_done_busy", busy[0], 1'b0);
      check("t4_idle_done_flag", done_flag[0], 32'd0);
      check("t4_idle_done_nostart", got_q.size(), gi);
      write_word(0, $urandom, 1);
      tick();
      check("t4_in_send", tx_start[0], 1'b1);
      tx_done_force = 1'b1;
      tick();
      tx_done_force = 1'b0;
      #1;
      n = 0;
      ok = 0;
      for (int c = 0; c < 2000; c++) begin
         if (tx_done[0]) n++;
         if (n == 8) begin
            clr_flags_n = 1'b0;
            @(posedge clk);
            #2;
            clr_flags_n = 1'b1;
            ok = 1;
            break;
         end
         @(posedge clk);
         #2;
      end
      check("t4_final_done_seen", {31'b0, ok}, 32'd1);
      check("t4_set_wins", done_flag[0], 32'd1);
      drain(0);
      compare_bytes("t4_bytes");

      // 5: reset after the third tx_start aborts the word
      w[0] = $urandom;
      write_word(0, w[0], 0);
      model_word(0, w[0], 3);
      base = start_cnt[0];
      ok = 0;
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk);
         #2;
         if (start_cnt[0] == base + 3) begin ok = 1; break; end
      end
      check("t5_third_start", {31'b0, ok}, 32'd1);
      reset = 1'b0;
      #1;
      check("t5_tx_start", tx_start[0], 1'b0);
      check("t5_tx_byte", tx_byte[0], 8'h00);
      check("t5_busy", busy[0], 1'b0);
      check("t5_fifo_empty", fifo_empty[0], 1'b1);
      check("t5_fifo_full", fifo_full[0], 1'b0);
      check("t5_overflow", overflow[0], 1'b0);
      check("t5_done_flag", done_flag[0], 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      compare_bytes("t5_aborted");
      w[1] = $urandom;
      write_word(0, w[1], 1);
      tick();
      check("t5_restart_chunk0", {2'd0, tx_byte[0]}, exp_q[ei]);
      drain(0);
      compare_bytes("t5_bytes");

      // 6: nibble without ASCII
      write_word(2, 32'h0000000F, 1);
      write_word(2, $urandom, 1);
      drain(2);
      compare_bytes("t6_bytes");
      check("t6_done_flag", done_flag[2], 32'd1);

      check("protocol", proto_err, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
